// File: rtl/rom_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_dma_pkg
// Description : Shared defaults, FSM state type and record layouts for the
//               multi-channel ROM DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_dma_pkg;

    localparam int DEF_ROM_ADDR_WIDTH = 16;
    localparam int DEF_ROM_DATA_WIDTH = 8;
    localparam int DEF_OUT_WIDTH      = 32;
    localparam int DEF_NUM_CH         = 2;
    localparam int DEF_ROM_RD_LAT     = 2;
    localparam int DEF_FIFO_DEPTH     = 16;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CHW  = clog2_min1(DEF_NUM_CH);
    localparam int DEF_BPW  = DEF_OUT_WIDTH / DEF_ROM_DATA_WIDTH;
    localparam int DEF_IDXW = clog2_min1(DEF_BPW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2
    } dma_state_e;

    // Read-pipeline tag for the default build; the engine declares a
    // width-generic copy with identical field order.
    typedef struct packed {
        logic                vld;
        logic [DEF_CHW-1:0]  ch;
        logic [DEF_IDXW-1:0] idx;
        logic                word_last;
        logic                xfer_last;
    } rd_tag_t;

    // Output FIFO entry for the default build: {ch, last, data}.
    typedef struct packed {
        logic [DEF_CHW-1:0]       ch;
        logic                     last;
        logic [DEF_OUT_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/generic_fifo.sv
`default_nettype none
// ============================================================================
// Module      : generic_fifo
// Description : Synchronous show-ahead FIFO, power-of-two depth, with
//               simultaneous push/pop and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module generic_fifo #(
    parameter int  FIFO_DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH      = 16,
    localparam int AW              = $clog2(FIFO_DEPTH),
    localparam int CW              = AW + 1
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] wr_data,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              count
);

    logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       w_wr;
    logic                       w_rd;

    assign full    = (r_count == CW'(FIFO_DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;

    // Storage array; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; a push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_dma_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rom_dma_rr_arb
// Description : Round-robin arbiter; search starts after the last granted
//               channel, pointer moves only when the grant is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_dma_rr_arb
    import rom_dma_pkg::*;
#(
    parameter int   NUM_CH = DEF_NUM_CH,
    localparam int  CHW    = clog2_min1(NUM_CH)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CHW-1:0]    grant_idx,
    output logic              grant_vld
);

    logic [CHW-1:0] r_last;
    int             w_cand;

    // Scan channels last+1 .. last+NUM_CH and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_cand    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = (int'(r_last) + i) % NUM_CH;
            if (!grant_vld && req[w_cand]) begin
                grant_vld = 1'b1;
                grant_idx = CHW'(w_cand);
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Remember the consumed grant; reset value makes channel 0 first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= CHW'(NUM_CH - 1);
        end else if (advance && grant_vld) begin
            r_last <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_dma_mc.sv
`default_nettype none
// ============================================================================
// Module      : rom_dma_mc
// Description : Multi-channel ROM DMA. Round-robin shares one ROM read port,
//               packs bytes little-endian into tagged output words.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_dma_mc
    import rom_dma_pkg::*;
#(
    parameter int  ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
    parameter int  ROM_DATA_WIDTH = DEF_ROM_DATA_WIDTH,
    parameter int  OUT_WIDTH      = DEF_OUT_WIDTH,
    parameter int  NUM_CH         = DEF_NUM_CH,
    parameter int  ROM_RD_LAT     = DEF_ROM_RD_LAT,
    parameter int  FIFO_DEPTH     = DEF_FIFO_DEPTH,
    localparam int CHW            = clog2_min1(NUM_CH)
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_vld,
    input  logic [CHW-1:0]            cfg_ch,
    input  logic [ROM_ADDR_WIDTH-1:0] cfg_base,
    input  logic [ROM_ADDR_WIDTH:0]   cfg_len,
    output logic                      cfg_ready,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [ROM_ADDR_WIDTH-1:0] rom_rd_addr,
    output logic                      CE_bar,
    output logic                      OE_bar,
    output logic                      WE_bar,
    input  logic [ROM_DATA_WIDTH-1:0] rom_rd_data,
    output logic                      out_vld,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic [CHW-1:0]            out_ch,
    output logic                      out_last
);

    localparam int BPW  = OUT_WIDTH / ROM_DATA_WIDTH;
    localparam int IDXW = clog2_min1(BPW);
    localparam int REMW = ROM_ADDR_WIDTH + 1;
    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam int FDW  = OUT_WIDTH + CHW + 1;

    typedef struct packed {
        logic            vld;
        logic [CHW-1:0]  ch;
        logic [IDXW-1:0] idx;
        logic            word_last;
        logic            xfer_last;
    } tag_t;

    dma_state_e                r_state, w_state_nxt;
    logic [ROM_ADDR_WIDTH-1:0] r_addr [NUM_CH];
    logic [REMW-1:0]           r_rem  [NUM_CH];
    logic [NUM_CH-1:0]         r_busy;
    logic [NUM_CH-1:0]         r_done;
    logic [CHW-1:0]            r_gch;
    logic [IDXW:0]             r_bidx;
    logic [IDXW:0]             r_nbytes;
    logic [FCW-1:0]            r_inflight;
    tag_t                      r_pipe [ROM_RD_LAT];
    logic [OUT_WIDTH-1:0]      r_word;

    logic                      w_cfg_wr, w_cfg_start;
    logic [NUM_CH-1:0]         w_req, w_gnt;
    logic [CHW-1:0]            w_gnt_idx;
    logic                      w_gnt_vld, w_credit, w_advance;
    logic [REMW-1:0]           w_sel_rem;
    logic                      w_issue, w_word_end;
    tag_t                      w_tag_in, w_tag_out;
    logic [OUT_WIDTH-1:0]      w_word;
    logic                      w_push, w_pop;
    logic [FDW-1:0]            w_fifo_rd;
    logic                      w_fifo_full, w_fifo_empty;
    logic [FCW-1:0]            w_fifo_count;

    assign cfg_ready   = ~r_busy[cfg_ch];
    assign w_cfg_wr    = cfg_vld & cfg_ready;
    assign w_cfg_start = w_cfg_wr & (cfg_len != '0);
    assign ch_busy     = r_busy;
    assign ch_done     = r_done;

    assign w_issue     = (r_state == ISSUE);
    assign w_word_end  = w_issue & ((r_bidx + 1'b1) == r_nbytes);
    assign rom_rd_addr = w_issue ? r_addr[r_gch] : '0;
    assign CE_bar      = ~w_issue;
    assign OE_bar      = ~w_issue;
    assign WE_bar      = 1'b1;

    // Granting reserves a FIFO slot so a completed word always has room.
    assign w_credit  = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < (FCW + 1)'(FIFO_DEPTH);
    assign w_advance = (r_state == ARB) & w_gnt_vld & w_credit;

    // Channels still owing reads compete; remaining count of the winner.
    always_comb begin
        w_req     = '0;
        w_sel_rem = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_req[c] = r_busy[c] & (r_rem[c] != '0);
            if (w_gnt[c]) w_sel_rem = w_sel_rem | r_rem[c];
        end
    end

    rom_dma_rr_arb #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_req),
        .advance   (w_advance),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx),
        .grant_vld (w_gnt_vld)
    );

    // Next-state logic; a config arriving in IDLE moves to ARB immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if ((|r_busy) || w_cfg_start) w_state_nxt = ARB;
            ARB: begin
                if (w_advance)                            w_state_nxt = ISSUE;
                else if (!(|r_busy) && !w_cfg_start)      w_state_nxt = IDLE;
            end
            ISSUE: begin
                if (w_word_end) w_state_nxt = ((|r_busy) || w_cfg_start) ? ARB : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and per-grant byte bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gch    <= '0;
            r_bidx   <= '0;
            r_nbytes <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                r_gch    <= w_gnt_idx;
                r_bidx   <= '0;
                r_nbytes <= (w_sel_rem >= REMW'(BPW)) ? (IDXW + 1)'(BPW) : w_sel_rem[IDXW:0];
            end else if (w_issue) begin
                r_bidx <= r_bidx + 1'b1;
            end
        end
    end

    // Words granted but not yet written into the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_advance, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Channel registers: config, read progress, completion on last-word pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_addr[c] <= '0;
                r_rem[c]  <= '0;
            end
            r_busy <= '0;
            r_done <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_done[c] <= 1'b0;
                if (w_cfg_wr && (cfg_ch == CHW'(c))) begin
                    if (cfg_len == '0) begin
                        r_done[c] <= 1'b1;
                    end else begin
                        r_busy[c] <= 1'b1;
                        r_addr[c] <= cfg_base;
                        r_rem[c]  <= cfg_len;
                    end
                end
                if (w_issue && (r_gch == CHW'(c))) begin
                    r_addr[c] <= r_addr[c] + 1'b1;
                    r_rem[c]  <= r_rem[c] - 1'b1;
                end
                if (w_pop && out_last && (out_ch == CHW'(c))) begin
                    r_busy[c] <= 1'b0;
                    r_done[c] <= 1'b1;
                end
            end
        end
    end

    // Tag for the byte being addressed this cycle.
    always_comb begin
        w_tag_in = '0;
        if (w_issue) begin
            w_tag_in.vld       = 1'b1;
            w_tag_in.ch        = r_gch;
            w_tag_in.idx       = r_bidx[IDXW-1:0];
            w_tag_in.word_last = w_word_end;
            w_tag_in.xfer_last = (r_rem[r_gch] == REMW'(1));
        end
    end

    // Tag delay line matching the ROM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_tag_in;
            for (int i = 1; i < ROM_RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tag_out = r_pipe[ROM_RD_LAT-1];
    assign w_push    = w_tag_out.vld & w_tag_out.word_last;

    // Byte 0 starts a fresh zeroed word; the returning byte fills its lane.
    always_comb begin
        w_word = (w_tag_out.idx == '0) ? '0 : r_word;
        for (int k = 0; k < BPW; k++) begin
            if (w_tag_out.idx == IDXW'(k)) w_word[k*ROM_DATA_WIDTH +: ROM_DATA_WIDTH] = rom_rd_data;
        end
    end

    // Partial-word accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
        end else if (w_tag_out.vld) begin
            r_word <= w_word;
        end
    end

    generic_fifo #(
        .FIFO_DATA_WIDTH (FDW),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push & ~w_fifo_full),
        .wr_data ({w_tag_out.ch, w_tag_out.xfer_last, w_word}),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign out_vld  = ~w_fifo_empty;
    assign w_pop    = out_vld & out_ready;
    assign out_data = out_vld ? w_fifo_rd[OUT_WIDTH-1:0] : '0;
    assign out_last = out_vld & w_fifo_rd[OUT_WIDTH];
    assign out_ch   = out_vld ? w_fifo_rd[FDW-1 -: CHW] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rom_dma_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_dma_mc
// Description : Scoreboard bench for rom_dma_mc (2 channels, 32-bit words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dma_mc;

    localparam int LAT   = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        ch;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_vld;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_base;
    logic [16:0] cfg_len;
    logic        cfg_ready;
    logic [1:0]  ch_busy, ch_done;
    logic [15:0] rom_rd_addr;
    logic        CE_bar, OE_bar, WE_bar;
    logic [7:0]  rom_rd_data;
    logic        out_vld, out_ready;
    logic [31:0] out_data;
    logic [0:0]  out_ch;
    logic        out_last;

    int          n_total = 0;
    int          n_pass  = 0;
    exp_t        exp_q[$];
    logic [15:0] addr_log[$];
    int          ce_cnt = 0;
    logic [1:0]  hs_due = '0;
    logic [1:0]  len0_due = '0;
    logic [1:0]  exp_done;
    logic        stall_prev = 1'b0;
    logic [33:0] stall_word;
    logic [15:0] a_pipe [LAT];

    always #5 clk = ~clk;

    rom_dma_mc #(
        .ROM_ADDR_WIDTH (16),
        .ROM_DATA_WIDTH (8),
        .OUT_WIDTH      (32),
        .NUM_CH         (2),
        .ROM_RD_LAT     (LAT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_vld     (cfg_vld),
        .cfg_ch      (cfg_ch),
        .cfg_base    (cfg_base),
        .cfg_len     (cfg_len),
        .cfg_ready   (cfg_ready),
        .ch_busy     (ch_busy),
        .ch_done     (ch_done),
        .rom_rd_addr (rom_rd_addr),
        .CE_bar      (CE_bar),
        .OE_bar      (OE_bar),
        .WE_bar      (WE_bar),
        .rom_rd_data (rom_rd_data),
        .out_vld     (out_vld),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last)
    );

    // ROM with ROM[a] = a[7:0], data returned LAT cycles after the address.
    always @(posedge clk) begin
        a_pipe[0] <= rom_rd_addr;
        for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign rom_rd_data = a_pipe[LAT-1][7:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t mk_word(input int ch, input int base, input int len, input int w);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < len) e.data[k*8 +: 8] = 8'(base + w * 4 + k);
        end
        e.ch   = 1'(ch);
        e.last = (w * 4 + 4 >= len);
        return e;
    endfunction

    function automatic void push_words(input int ch, input int base, input int len);
        for (int w = 0; w * 4 < len; w++) exp_q.push_back(mk_word(ch, base, len, w));
    endfunction

    // Called at posedge+1; the write lands on the next edge.
    task automatic cfg(input int ch, input int base, input int len);
        cfg_vld  = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_base = 16'(base);
        cfg_len  = 17'(len);
        @(posedge clk); #1;
        cfg_vld = 1'b0;
        if (len == 0) len0_due[ch] = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ch_busy != 2'b00) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_left", exp_q.size(), 0);
        check("drain_busy", ch_busy, 2'b00);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard, stall hold, done pulses, read log.
    always @(negedge clk) begin
        if (reset) begin
            hs_due     = '0;
            len0_due   = '0;
            stall_prev = 1'b0;
        end else begin
            if (!CE_bar) begin
                ce_cnt++;
                addr_log.push_back(rom_rd_addr);
            end
            exp_done = hs_due | len0_due;
            if (ch_done != 2'b00 || exp_done != 2'b00) begin
                check("ch_done", ch_done, exp_done);
                check("busy_at_done", ch_busy & exp_done, 2'b00);
            end
            hs_due   = '0;
            len0_due = '0;
            if (stall_prev) check("stall_hold", {out_ch, out_last, out_data}, stall_word);
            stall_prev = out_vld & ~out_ready;
            stall_word = {out_ch, out_last, out_data};
            if (out_vld && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_vld, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ch", out_ch, e.ch);
                    check("out_last", out_last, e.last);
                    if (out_last) hs_due[out_ch] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ce0;
        logic [15:0] v_addr;
        exp_t e0;

        reset = 1'b1; cfg_vld = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_len = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        cfg_ch = 1'b0; #1; check("rst_cfg_ready0", cfg_ready, 1'b1);
        cfg_ch = 1'b1; #1; check("rst_cfg_ready1", cfg_ready, 1'b1);
        check("rst_busy", ch_busy, 2'b00);
        check("rst_done", ch_done, 2'b00);
        check("rst_addr", rom_rd_addr, 16'h0);
        check("rst_ce_oe_we", {CE_bar, OE_bar, WE_bar}, 3'b111);
        check("rst_out", {out_vld, out_ch, out_last, out_data}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single channel, two full words
        push_words(0, 'h10, 8);
        cfg(0, 'h10, 8);
        check("t1_busy_T1", ch_busy, 2'b01);
        check("t1_ce_T1", CE_bar, 1'b1);
        @(posedge clk); #1;
        check("t1_addr_T2", rom_rd_addr, 16'h0010);
        check("t1_ce_oe_T2", {CE_bar, OE_bar}, 2'b00);
        drain(300);

        // Interleaved channels, configured back-to-back
        exp_q.push_back(mk_word(0, 'h0000, 5, 0));
        exp_q.push_back(mk_word(1, 'h0100, 4, 0));
        e0 = mk_word(0, 'h0000, 5, 1);
        exp_q.push_back(e0);
        cfg(0, 'h0000, 5);
        cfg(1, 'h0100, 4);
        cfg_ch = 1'b0; #1;
        check("t2_cfg_ready_busy", cfg_ready, 1'b0);
        drain(300);

        // Address wrap
        addr_log.delete();
        push_words(1, 'hFFFE, 4);
        cfg(1, 'hFFFE, 4);
        drain(300);
        check("t3_nreads", addr_log.size(), 4);
        for (int i = 0; i < addr_log.size() && i < 4; i++) begin
            v_addr = 16'hFFFE + 16'(i);
            check("t3_addr", addr_log[i], v_addr);
        end

        // Zero-length transfer
        ce0 = ce_cnt;
        cfg(0, 'h50, 0);
        check("t4_busy", ch_busy, 2'b00);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_reads", ce_cnt - ce0, 0);

        // Backpressure fills the FIFO exactly, then releases in order
        out_ready = 1'b0;
        ce0 = ce_cnt;
        push_words(0, 'h200, 128);
        cfg(0, 'h200, 128);
        repeat (200) @(posedge clk);
        #1;
        check("t5_reads_stalled", ce_cnt - ce0, DEPTH * 4);
        check("t5_out_vld", out_vld, 1'b1);
        cfg_ch = 1'b0; #1;
        check("t5_cfg_ready_busy", cfg_ready, 1'b0);
        cfg(0, 'h300, 4);
        repeat (20) @(posedge clk);
        #1;
        check("t5_still_stalled", ce_cnt - ce0, DEPTH * 4);
        out_ready = 1'b1;
        drain(1000);

        // Asynchronous reset during ISSUE
        push_words(1, 'h400, 64);
        cfg(1, 'h400, 64);
        for (int n = 0; n < 20 && CE_bar; n++) begin
            @(posedge clk); #1;
        end
        check("t6_issue_seen", CE_bar, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_addr", rom_rd_addr, 16'h0);
        check("t6_ce_oe_we", {CE_bar, OE_bar, WE_bar}, 3'b111);
        check("t6_busy_done", {ch_busy, ch_done}, 4'b0000);
        check("t6_out", {out_vld, out_ch, out_last, out_data}, '0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_words(1, 'h20, 6);
        cfg(1, 'h20, 6);
        drain(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
